// File: rtl/match_round_controller.sv
// match_round_controller: best-of-N fight sequencer (IDLE -> COUNTDOWN -> FIGHT -> ROUND_END -> MATCH_END).
// Optional macro SUDDEN_DEATH_EN: an equal-health timeout keeps fighting, untimed, until a KO.
module match_round_controller #(
   parameter int HP_W            = 9,
   parameter int TICK_HZ         = 20,
   parameter int COUNTDOWN_TICKS = 60,
   parameter int ROUND_TICKS     = 1200,
   parameter int ROUND_END_TICKS = 40,
   parameter int HOLD_TICKS      = 40,
   parameter int ROUNDS_TO_WIN   = 2,
   parameter int MAX_ROUNDS      = 5
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            tick,
   input  logic            start_btn,
   input  logic [HP_W-1:0] health_1,
   input  logic [HP_W-1:0] health_2,
   output logic            round_reset,
   output logic            freeze,
   output logic [2:0]      state,
   output logic [1:0]      countdown,
   output logic [6:0]      seconds_left,
   output logic [1:0]      round_wins_1,
   output logic [1:0]      round_wins_2,
   output logic [2:0]      round_num,
   output logic [1:0]      match_winner
);

   localparam int MAX_A = (COUNTDOWN_TICKS > ROUND_END_TICKS) ? COUNTDOWN_TICKS : ROUND_END_TICKS;
   localparam int MAX_B = (HOLD_TICKS > TICK_HZ) ? HOLD_TICKS : TICK_HZ;
   localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W = $clog2(MAX_T + 1);

   localparam logic [CNT_W-1:0] CD_LAST    = CNT_W'(COUNTDOWN_TICKS - 1);
   localparam logic [CNT_W-1:0] RE_LAST    = CNT_W'(ROUND_END_TICKS - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_TICKS - 1);
   localparam logic [CNT_W-1:0] SEC_LAST   = CNT_W'(TICK_HZ - 1);
   localparam logic [6:0]       ROUND_SECS = 7'(ROUND_TICKS / TICK_HZ);
   localparam logic [1:0]       WIN_CNT    = 2'(ROUNDS_TO_WIN);
   localparam logic [2:0]       LAST_ROUND = 3'(MAX_ROUNDS);
   localparam logic [CNT_W+1:0] CD_MUL     = (CNT_W+2)'(3);
   localparam logic [CNT_W+1:0] CD_DIV     = (CNT_W+2)'(COUNTDOWN_TICKS);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_COUNTDOWN = 3'd1,
      S_FIGHT     = 3'd2,
      S_ROUND_END = 3'd3,
      S_MATCH_END = 3'd4
   } state_t;

   state_t           cur_state;
   state_t           nxt_state;
   logic             start_q;
   logic [CNT_W-1:0] tick_cnt;
   logic [6:0]       seconds_q;
   logic [1:0]       wins1_q;
   logic [1:0]       wins2_q;
   logic [2:0]       round_num_q;
   logic [1:0]       winner_q;
   logic             round_reset_q;

   logic             start_rise;
   logic             round_over;
   logic             p1_point;
   logic             p2_point;
   logic             match_done;
   logic [1:0]       winner_d;
   logic             pulse_d;
   logic [CNT_W+1:0] cd_scaled;
   logic [CNT_W+1:0] cd_step;

   assign start_rise = start_btn & ~start_q;
   assign match_done = (wins1_q == WIN_CNT) || (wins2_q == WIN_CNT) || (round_num_q == LAST_ROUND);

   // KO checks take priority over the clock; both-down is a draw.
   always_comb begin
      round_over = 1'b0;
      p1_point   = 1'b0;
      p2_point   = 1'b0;
      if (health_1 == '0 && health_2 == '0) begin
         round_over = 1'b1;
      end else if (health_1 == '0) begin
         round_over = 1'b1;
         p2_point   = 1'b1;
      end else if (health_2 == '0) begin
         round_over = 1'b1;
         p1_point   = 1'b1;
      end else if (seconds_q == '0) begin
         if (health_1 > health_2) begin
            round_over = 1'b1;
            p1_point   = 1'b1;
         end else if (health_2 > health_1) begin
            round_over = 1'b1;
            p2_point   = 1'b1;
         end else begin
`ifdef SUDDEN_DEATH_EN
            round_over = 1'b0;
`else
            round_over = 1'b1;
`endif
         end
      end
   end

   always_comb begin
      winner_d = 2'b11;
      if (wins1_q > wins2_q)
         winner_d = 2'b01;
      else if (wins2_q > wins1_q)
         winner_d = 2'b10;
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cur_state <= S_IDLE;
      else
         cur_state <= nxt_state;
   end

   // Next-state logic
   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         S_IDLE:      if (start_rise) nxt_state = S_COUNTDOWN;
         S_COUNTDOWN: if (tick && tick_cnt == CD_LAST) nxt_state = S_FIGHT;
         S_FIGHT:     if (round_over) nxt_state = S_ROUND_END;
         S_ROUND_END: if (tick && tick_cnt == RE_LAST) nxt_state = match_done ? S_MATCH_END : S_COUNTDOWN;
         S_MATCH_END: if (tick && start_btn && tick_cnt == HOLD_LAST) nxt_state = S_IDLE;
         default:     nxt_state = S_IDLE;
      endcase
   end

   assign pulse_d = ((nxt_state == S_COUNTDOWN) && (cur_state != S_COUNTDOWN)) ||
                    ((cur_state == S_MATCH_END) && (nxt_state == S_IDLE));

   // One counter serves every timed state: elapsed ticks, sub-second phase, or start hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         start_q       <= 1'b0;
         round_reset_q <= 1'b0;
         tick_cnt      <= '0;
      end else begin
         start_q       <= start_btn;
         round_reset_q <= pulse_d;
         if (nxt_state != cur_state) begin
            tick_cnt <= '0;
         end else begin
            case (cur_state)
               S_COUNTDOWN, S_ROUND_END: begin
                  if (tick) tick_cnt <= tick_cnt + 1'b1;
               end
               S_FIGHT: begin
                  if (tick) tick_cnt <= (tick_cnt == SEC_LAST) ? '0 : tick_cnt + 1'b1;
               end
               S_MATCH_END: begin
                  if (!start_btn)
                     tick_cnt <= '0;
                  else if (tick)
                     tick_cnt <= tick_cnt + 1'b1;
               end
               default: tick_cnt <= '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seconds_q <= '0;
      end else if (cur_state == S_COUNTDOWN && nxt_state == S_FIGHT) begin
         seconds_q <= ROUND_SECS;
      end else if (cur_state == S_FIGHT && nxt_state == S_FIGHT && tick &&
                   tick_cnt == SEC_LAST && seconds_q != '0) begin
         seconds_q <= seconds_q - 1'b1;
      end else if (cur_state == S_MATCH_END && nxt_state == S_IDLE) begin
         seconds_q <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wins1_q     <= '0;
         wins2_q     <= '0;
         round_num_q <= '0;
         winner_q    <= '0;
      end else begin
         case (cur_state)
            S_IDLE: begin
               if (nxt_state == S_COUNTDOWN) begin
                  wins1_q     <= '0;
                  wins2_q     <= '0;
                  round_num_q <= 3'd1;
                  winner_q    <= '0;
               end
            end
            S_FIGHT: begin
               if (round_over) begin
                  if (p1_point && wins1_q != 2'd3) wins1_q <= wins1_q + 1'b1;
                  if (p2_point && wins2_q != 2'd3) wins2_q <= wins2_q + 1'b1;
               end
            end
            S_ROUND_END: begin
               if (nxt_state == S_COUNTDOWN)
                  round_num_q <= round_num_q + 1'b1;
               else if (nxt_state == S_MATCH_END)
                  winner_q <= winner_d;
            end
            S_MATCH_END: begin
               if (nxt_state == S_IDLE) begin
                  wins1_q     <= '0;
                  wins2_q     <= '0;
                  round_num_q <= '0;
                  winner_q    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign cd_scaled = {2'b00, tick_cnt} * CD_MUL;
   assign cd_step   = cd_scaled / CD_DIV;

   // Output logic
   always_comb begin
      state        = cur_state;
      freeze       = (cur_state != S_FIGHT);
      round_reset  = round_reset_q;
      seconds_left = seconds_q;
      round_wins_1 = wins1_q;
      round_wins_2 = wins2_q;
      round_num    = round_num_q;
      match_winner = winner_q;
      countdown    = 2'd0;
      if (cur_state == S_COUNTDOWN) begin
         if (cd_step == '0)
            countdown = 2'd3;
         else if (cd_step == (CNT_W+2)'(1))
            countdown = 2'd2;
         else
            countdown = 2'd1;
      end
   end

endmodule

// File: doc/match_round_controller.md
Name: match_round_controller

Overview:
Sequences the fight datapath: physics, health and input handlers. Runs a best-of-N match made of timed rounds, with a pre-round countdown and end-of-round pauses. Issues a one-cycle round_reset to the physics and health blocks, and a freeze level that gates player and bot inputs outside active fighting. Game state, seconds remaining and round scores go to the 7-seg menu and status bar.

Parameters:
HP_W, 9, width of health inputs
TICK_HZ, 20, game ticks per second; must be at least 1
COUNTDOWN_TICKS, 60, ticks spent in COUNTDOWN (3 s)
ROUND_TICKS, 1200, round length in ticks; must be a multiple of TICK_HZ
ROUND_END_TICKS, 40, pause after each round
HOLD_TICKS, 40, consecutive ticks start_btn must be held in MATCH_END to return to IDLE
ROUNDS_TO_WIN, 2, round wins needed to take the match
MAX_ROUNDS, 5, hard cap on rounds played

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
tick  in  1  single-clk game-tick enable pulse (20 Hz), clk domain
start_btn  in  1  start/confirm level, already synchronised
health_1  in  HP_W  player 1 health
health_2  in  HP_W  player 2 health
round_reset  out  1  one-clk pulse; resets physics, health, bullets
freeze  out  1  high whenever state != FIGHT
state  out  3  0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 ROUND_END, 4 MATCH_END
countdown  out  2  3/2/1 during COUNTDOWN, else 0
seconds_left  out  7  whole seconds remaining in the round
round_wins_1  out  2  rounds won by player 1
round_wins_2  out  2  rounds won by player 2
round_num  out  3  current round, 1-based; 0 in IDLE
match_winner  out  2  00 none, 01 P1, 10 P2, 11 draw

Behaviour:
- Interface is fixed: single clock clk; reset_n is asynchronous, active-low.
- Reset values: state=IDLE, freeze=1, round_reset=0, and countdown, seconds_left, wins, round_num, match_winner all 0. All internal counters clear.
- Edge detect: start_rise = start_btn & ~start_q, where start_q is a registered copy.
- Tick counters advance only on clk edges where tick=1. All other logic evaluates every clk.
- IDLE:
  - On start_rise: go to COUNTDOWN; pulse round_reset; clear wins; round_num=1; match_winner=0.
- COUNTDOWN:
  - countdown = 3 - floor(3*elapsed/COUNTDOWN_TICKS), saturated to the range 1..3.
  - Health is ignored here because it is still reloading after round_reset.
  - After COUNTDOWN_TICKS ticks: go to FIGHT; seconds_left = ROUND_TICKS/TICK_HZ.
- FIGHT:
  - freeze=0.
  - seconds_left decrements once every TICK_HZ ticks and holds at 0.
- FIGHT round end, checked every clk in priority order:
  - health_1==0 and health_2==0 → draw.
  - health_1==0 → P2 wins the round.
  - health_2==0 → P1 wins the round.
  - seconds_left==0 → higher health wins; equal health is a draw.
  - A winning player's wins counter increments (saturates at 3); a draw changes neither counter. Go to ROUND_END.
- ROUND_END:
  - After ROUND_END_TICKS ticks, evaluate:
    - If either wins counter == ROUNDS_TO_WIN, or round_num == MAX_ROUNDS: go to MATCH_END. match_winner is the side with more wins; equal wins gives 11.
    - Otherwise: round_num+1, pulse round_reset, go to COUNTDOWN.
- MATCH_END:
  - A hold counter counts consecutive ticks with start_btn=1 and clears when start_btn=0.
  - When it reaches HOLD_TICKS: pulse round_reset, go to IDLE, clear scores and round_num.
- round_reset is registered and lasts exactly one clk, asserted in the same cycle the new state is registered.
- Counters reload on every state entry, so no count carries across states.
- start_rise outside IDLE is ignored. tick and start_rise in the same cycle are both honoured.
- reset_n low at any point: immediate return to reset values, with no round_reset pulse.

Optional Feature:
SUDDEN_DEATH_EN
- Defined: a timeout with equal health does not draw. The block stays in FIGHT with seconds_left=0, untimed, until a health reaches 0, then applies the normal KO rules.
- Undefined: a timeout with equal health is a draw, as above.

Test Plan:
Use bench parameters TICK_HZ=2, COUNTDOWN_TICKS=3, ROUND_TICKS=10, ROUND_END_TICKS=2, HOLD_TICKS=4; tick asserted every 4th clk.
1. Reset, then start_btn rising edge in IDLE → round_reset for 1 clk, state=1, countdown=3; 3 ticks later state=2, seconds_left=5, freeze=0.
2. In FIGHT, drive health_2=0 and health_1=100 → state=3 on the next clk, round_wins_1=1; 2 ticks later round_num=2, state=1, round_reset pulse.
3. Player 1 wins rounds 1 and 2 by KO → state=4, match_winner=01, round_wins_1=2, freeze=1.
4. Timeout with health_1=50, health_2=80 → round_wins_2 increments. Timeout with 80/80 → no wins change (macro off), or state stays 2 until a KO (SUDDEN_DEATH_EN).
5. In MATCH_END, hold start_btn for 3 ticks, release, then hold for 4 ticks → no exit after the first hold; exit to IDLE with a round_reset pulse at the 4th tick of the second hold.
6. Drop reset_n for 1 clk mid-FIGHT → all outputs return to reset values at once; no round_reset pulse.
